// File: rtl/kpn_subtractor_scheduler.sv
// rtl/kpn_subtractor_scheduler.sv - round-robin scheduler sharing one registered subtractor among NUM_REQ channels
// Optional KPN_SUB_FIXED_PRIO_EN selects fixed lowest-index-wins priority instead of round-robin.
module kpn_subtractor_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         sub_entry_1,
  output logic [WIDTH-1:0]         sub_entry_2,
  input  logic [WIDTH-1:0]         sub_output_1,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic [ID_W-1:0]          res_id,
  output logic                     res_borrow,
  output logic                     busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXEC    = 2'd1,
    S_CAPTURE = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t           state_q;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [ID_W-1:0]  pend_id_q;
  logic             pend_borrow_q;

  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [ID_W-1:0]  rr_ptr_d;

`ifdef KPN_SUB_FIXED_PRIO_EN
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(i);
      end
    end
  end
`else
  // Candidate k is rr_ptr_q + k folded back into 0..NUM_REQ-1; the first valid candidate wins.
  always_comb begin
    logic [ID_W:0] cand;
    logic          hit;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      hit = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cand == (ID_W+1)'(i) && req_valid[i]) begin
          hit = 1'b1;
        end
      end
      if (!grant_found && hit) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end
`endif

  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
      req_ready[i] = (state_q == S_IDLE) && grant_found && (grant_idx == ID_W'(i));
    end
  end

  assign rr_ptr_d = (pend_id_q == ID_W'(NUM_REQ - 1)) ? '0 : pend_id_q + ID_W'(1);
  assign busy     = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      pend_id_q     <= '0;
      pend_borrow_q <= 1'b0;
      sub_entry_1   <= '0;
      sub_entry_2   <= '0;
      res_valid     <= 1'b0;
      res_data      <= '0;
      res_id        <= '0;
      res_borrow    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_found) begin
            sub_entry_1   <= sel_a;
            sub_entry_2   <= sel_b;
            pend_id_q     <= grant_idx;
            pend_borrow_q <= (sel_a < sel_b);
            state_q       <= S_EXEC;
          end
        end
        // Entries stay put here so the subtractor registers the difference on this edge.
        S_EXEC: state_q <= S_CAPTURE;
        S_CAPTURE: begin
          res_data   <= sub_output_1;
          res_id     <= pend_id_q;
          res_borrow <= pend_borrow_q;
          res_valid  <= 1'b1;
          state_q    <= S_HOLD;
        end
        S_HOLD: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
`ifndef KPN_SUB_FIXED_PRIO_EN
            rr_ptr_q  <= rr_ptr_d;
`endif
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
